// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC, registered training
// from resolved branches, multi-cycle invalidate sweep. Define BTB_2BIT_PRED_EN for 2-bit counters.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            flush_i,
    output logic            busy_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [XLEN-1:0]    ta_q  [ENTRIES];
    logic [XLEN-1:0]    ta_d  [ENTRIES];
`ifdef BTB_2BIT_PRED_EN
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];
`else
    logic [ENTRIES-1:0] t_q, t_d;
`endif

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_taken_bit;
    logic             upd_hit;

    assign lk_idx = if_pc_i[IDX_W+1:2];
    assign lk_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Byte offset and PC bits above the tag do not take part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDX_W+TAG_W+2], if_pc_i[1:0],
                              upd_pc_i[XLEN-1:IDX_W+TAG_W+2], upd_pc_i[1:0]};

`ifdef BTB_2BIT_PRED_EN
    assign lk_taken_bit = ctr_q[lk_idx][1];
`else
    assign lk_taken_bit = t_q[lk_idx];
`endif

    always_comb begin
        busy_o        = (state_q == StSweep);
        hit_o         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy_o;
        pred_taken_o  = hit_o && lk_taken_bit;
        pred_target_o = pred_taken_o ? ta_q[lk_idx] : (if_pc_i + XLEN'(4));
        upd_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        ta_d    = ta_q;
`ifdef BTB_2BIT_PRED_EN
        ctr_d   = ctr_q;
`else
        t_d     = t_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Flush has priority; a coincident update is dropped.
                if (flush_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end else if (upd_valid_i) begin
                    if (upd_hit) begin
                        if (upd_taken_i) begin
                            ta_d[up_idx] = upd_target_i;
                        end
`ifdef BTB_2BIT_PRED_EN
                        if (upd_taken_i) begin
                            ctr_d[up_idx] = (ctr_q[up_idx] == 2'b11) ? 2'b11
                                                                     : ctr_q[up_idx] + 2'b01;
                        end else begin
                            ctr_d[up_idx] = (ctr_q[up_idx] == 2'b00) ? 2'b00
                                                                     : ctr_q[up_idx] - 2'b01;
                        end
`else
                        t_d[up_idx] = upd_taken_i;
`endif
                    end else if (upd_taken_i) begin
                        valid_d[up_idx] = 1'b1;
                        tag_d[up_idx]   = up_tag;
                        ta_d[up_idx]    = upd_target_i;
`ifdef BTB_2BIT_PRED_EN
                        ctr_d[up_idx]   = 2'b10;
`else
                        t_d[up_idx]     = 1'b1;
`endif
                    end
                end
            end
            StSweep: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + IDX_W'(1);
                if (flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= '0;
`ifdef BTB_2BIT_PRED_EN
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
`else
            t_q     <= '0;
`endif
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ta_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ta_q    <= ta_d;
`ifdef BTB_2BIT_PRED_EN
            ctr_q   <= ctr_d;
`else
            t_q     <= t_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected outputs, a monitor
// compares them against the DUT on the falling edge.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic        hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        flush_i;
    logic        busy_o;

    always #5 clk = ~clk;

    branch_target_buffer #(
        .ENTRIES(16),
        .TAG_W  (6),
        .XLEN   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc_i      (if_pc_i),
        .hit_o        (hit_o),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   stim_done = 1'b0;

    // Monitor: one queued expectation consumed per requested cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL no_expectation: DUT presented hit=%0b with empty scoreboard",
                             hit_o);
                end else begin
                    e = exp_q.pop_front();
                    if (hit_o === e.hit && pred_taken_o === e.taken &&
                        pred_target_o === e.target && busy_o === e.busy) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got hit=%0b taken=%0b target=%08h busy=%0b, want hit=%0b taken=%0b target=%08h busy=%0b",
                                 e.name, hit_o, pred_taken_o, pred_target_o, busy_o,
                                 e.hit, e.taken, e.target, e.busy);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic h, input logic t,
                              input logic [31:0] tgt, input logic b);
        exp_t e;
        e.name = name; e.hit = h; e.taken = t; e.target = tgt; e.busy = b;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = tk;
        upd_target_i = tgt;
    endtask

    task automatic no_upd();
        upd_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; if_pc_i = 32'h40; flush_i = 1'b0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;

        cyc(); expect_out("in_reset", 1'b0, 1'b0, 32'h44, 1'b0);
        cyc(); rst_n = 1'b1;
        cyc(); expect_out("after_reset", 1'b0, 1'b0, 32'h44, 1'b0);

        // Allocate 0x40; same-cycle lookup sees the old (empty) entry.
        cyc(); upd(32'h40, 1'b1, 32'h100); expect_out("upd_cycle_no_bypass", 1'b0, 1'b0, 32'h44, 1'b0);
        cyc(); no_upd(); expect_out("alloc_hit", 1'b1, 1'b1, 32'h100, 1'b0);
        // Alias 0x440 (idx 0, tag 17) not-taken: no allocation.
        cyc(); upd(32'h440, 1'b0, 32'h999); expect_out("alias_nt_cycle", 1'b1, 1'b1, 32'h100, 1'b0);
        cyc(); no_upd(); expect_out("alias_nt_keeps", 1'b1, 1'b1, 32'h100, 1'b0);
        cyc(); if_pc_i = 32'h440; expect_out("alias_miss", 1'b0, 1'b0, 32'h444, 1'b0);
        cyc(); upd(32'h440, 1'b1, 32'h200); expect_out("alias_t_cycle", 1'b0, 1'b0, 32'h444, 1'b0);
        cyc(); no_upd(); if_pc_i = 32'h40; expect_out("replaced_old_miss", 1'b0, 1'b0, 32'h44, 1'b0);
        cyc(); if_pc_i = 32'h440; expect_out("replaced_new_hit", 1'b1, 1'b1, 32'h200, 1'b0);

        // Train 0x40 back in, then not-taken / taken outcomes on a hit.
        cyc(); if_pc_i = 32'h40; upd(32'h40, 1'b1, 32'h100);
        expect_out("realloc_cycle", 1'b0, 1'b0, 32'h44, 1'b0);
        cyc(); upd(32'h40, 1'b0, 32'h0); expect_out("nt_upd_cycle", 1'b1, 1'b1, 32'h100, 1'b0);
        cyc(); no_upd(); expect_out("after_nt", 1'b1, 1'b0, 32'h44, 1'b0);
        cyc(); upd(32'h40, 1'b1, 32'h100); expect_out("t_upd_cycle", 1'b1, 1'b0, 32'h44, 1'b0);
        cyc(); upd(32'h40, 1'b1, 32'h104); expect_out("after_t", 1'b1, 1'b1, 32'h100, 1'b0);
        cyc(); upd(32'h40, 1'b0, 32'h0); expect_out("target_refresh", 1'b1, 1'b1, 32'h104, 1'b0);
        cyc(); no_upd();
`ifdef BTB_2BIT_PRED_EN
        expect_out("strong_then_nt", 1'b1, 1'b1, 32'h104, 1'b0);
`else
        expect_out("last_outcome_nt", 1'b1, 1'b0, 32'h44, 1'b0);
`endif
        cyc(); if_pc_i = 32'hFFFF_FFFC; expect_out("pc_wrap", 1'b0, 1'b0, 32'h0, 1'b0);

        // Fill idx 0..3, then flush with a coincident update that must be dropped.
        cyc(); upd(32'h40, 1'b1, 32'h1000);
        cyc(); upd(32'h84, 1'b1, 32'h1004);
        cyc(); upd(32'hC8, 1'b1, 32'h1008);
        cyc(); upd(32'h10C, 1'b1, 32'h100C);
        cyc(); no_upd(); if_pc_i = 32'h84; expect_out("filled_hit", 1'b1, 1'b1, 32'h1004, 1'b0);
        cyc(); flush_i = 1'b1; upd(32'h1C, 1'b1, 32'h500);
        expect_out("flush_cycle_idle", 1'b1, 1'b1, 32'h1004, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(); flush_i = 1'b0;
            if (i == 3) upd(32'h20, 1'b1, 32'h600); else no_upd();
            expect_out($sformatf("sweep_%0d", i), 1'b0, 1'b0, 32'h88, 1'b1);
        end
        cyc(); no_upd(); expect_out("sweep_done", 1'b0, 1'b0, 32'h88, 1'b0);
        begin
            logic [31:0] pcs [6];
            pcs = '{32'h40, 32'hC8, 32'h10C, 32'h1C, 32'h20, 32'h84};
            for (int i = 0; i < 6; i++) begin
                cyc(); if_pc_i = pcs[i];
                expect_out($sformatf("post_flush_miss_%08h", pcs[i]), 1'b0, 1'b0,
                           pcs[i] + 32'd4, 1'b0);
            end
        end

        // Flush re-pulsed on the 5th busy cycle: 5 + 16 busy cycles.
        cyc(); if_pc_i = 32'h40; upd(32'h40, 1'b1, 32'h100);
        cyc(); no_upd(); flush_i = 1'b1; expect_out("reflush_start", 1'b1, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 21; i++) begin
            cyc(); flush_i = (i == 4);
            expect_out($sformatf("reflush_busy_%0d", i), 1'b0, 1'b0, 32'h44, 1'b1);
        end
        cyc(); flush_i = 1'b0; expect_out("reflush_done", 1'b0, 1'b0, 32'h44, 1'b0);

        // Asynchronous reset mid-sweep and mid-update; idx 15 not yet swept.
        cyc(); upd(32'h13C, 1'b1, 32'h700);
        cyc(); no_upd(); if_pc_i = 32'h13C; expect_out("idx15_hit", 1'b1, 1'b1, 32'h700, 1'b0);
        cyc(); flush_i = 1'b1;
        cyc(); flush_i = 1'b0;
        cyc();
        cyc(); upd(32'h84, 1'b1, 32'h900); expect_out("pre_reset_busy", 1'b0, 1'b0, 32'h140, 1'b1);
        cyc(); #1; rst_n = 1'b0; expect_out("async_reset_now", 1'b0, 1'b0, 32'h140, 1'b0);
        cyc(); expect_out("held_reset", 1'b0, 1'b0, 32'h140, 1'b0);
        cyc(); #1; rst_n = 1'b1; no_upd();
        cyc(); expect_out("reset_idx15_miss", 1'b0, 1'b0, 32'h140, 1'b0);
        cyc(); if_pc_i = 32'h84; expect_out("reset_upd_dropped", 1'b0, 1'b0, 32'h88, 1'b0);
        cyc(); if_pc_i = 32'h40; expect_out("reset_idx0_miss", 1'b0, 1'b0, 32'h44, 1'b0);

        cyc();
        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        stim_done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus did not complete");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer in the IF stage, built on the CACHE_BRANCH entry format (V, TAG, TA, T).
- Predicts taken/target for the current fetch PC; its outputs feed the PC-select and hazard logic (PCSrc).
- Entries are trained by resolved branch/jump outcomes from the MEM stage.
- Supports a multi-cycle invalidate sweep for flush/restart.

Parameters:
- ENTRIES, 16, number of entries; power of two, >= 2; IDX_W = log2(ENTRIES)
- TAG_W, 6, stored tag width (matches CACHE_BRANCH.TAG)
- XLEN, 32, PC/target width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc_i  in  XLEN  fetch PC to look up
- hit_o  out  1  lookup hit (valid entry, tag match, not sweeping)
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  XLEN  next-PC prediction
- upd_valid_i  in  1  resolved control-transfer update strobe
- upd_pc_i  in  XLEN  PC of the resolved branch/jump
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  XLEN  actual target address
- flush_i  in  1  start invalidate-all sweep
- busy_o  out  1  sweep in progress

Behaviour:
- One clock; reset is asynchronous and active-low.
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored.
- Lookup is combinational, same cycle as if_pc_i:
  - hit_o = V[idx] & (TAG[idx]==tag) & ~busy_o.
  - pred_taken_o = hit_o & T[idx].
  - pred_target_o = TA[idx] when pred_taken_o, else if_pc_i+4 (mod 2^XLEN; 0xFFFFFFFC+4 wraps to 0).
- Update is registered: it takes effect at the posedge where upd_valid_i=1.
  - Hit on upd_pc: T <= upd_taken_i; TA <= upd_target_i only if upd_taken_i.
  - Miss and upd_taken_i=1: allocate or replace. V<=1, TAG<=tag, TA<=upd_target_i, T<=1.
  - Miss and upd_taken_i=0: no change (no allocation on not-taken).
- Same-cycle lookup and update to the same idx: the lookup sees the old contents (no bypass). The new contents are visible from the next cycle.
- FSM states IDLE and SWEEP, with a sweep counter cnt[IDX_W-1:0]:
  - IDLE + flush_i: go to SWEEP, cnt<=0.
  - SWEEP: each cycle V[cnt]<=0 and cnt<=cnt+1. When cnt==ENTRIES-1, clear that entry and return to IDLE.
  - The sweep takes exactly ENTRIES cycles. busy_o=1 for all of them.
  - flush_i during SWEEP restarts the sweep at cnt=0.
- During SWEEP:
  - hit_o=0, pred_taken_o=0, pred_target_o=if_pc_i+4.
  - upd_valid_i is ignored (dropped, not queued).
- flush_i and upd_valid_i in the same IDLE cycle: flush wins and the update is dropped.
- Reset:
  - All V<=0; TAG/TA/T<=0; state IDLE; cnt<=0; busy_o=0.
  - Reset mid-sweep aborts the sweep. All entries are invalid anyway.
- Outputs under reset: hit_o=0, pred_taken_o=0, busy_o=0, pred_target_o=if_pc_i+4.

Optional Feature:
- Macro: BTB_2BIT_PRED_EN.
- Defined:
  - T is replaced by a 2-bit saturating counter ctr.
  - Allocation sets ctr=2'b10.
  - Hit updates: taken increments (saturates at 2'b11); not-taken decrements (saturates at 2'b00).
  - pred_taken_o = hit_o & ctr[1].
  - TA is still updated only on taken.
- Undefined: 1-bit last-outcome T as described above.
- Reset clears ctr to 2'b00.

Test Plan:
- Reset, then if_pc_i=0x00000040 -> hit_o=0, pred_taken_o=0, pred_target_o=0x00000044, busy_o=0.
- Update pc=0x00000040, taken=1, target=0x00000100; next cycle look up 0x40 -> hit_o=1, pred_taken_o=1, pred_target_o=0x00000100. In the update cycle itself the lookup of 0x40 shows hit_o=0.
- Alias: after the entry above, update pc=0x00000440 (same idx, different tag), taken=0 -> no change; look up 0x40 still hits. Update 0x440 taken=1, target=0x200 -> 0x40 misses and 0x440 hits with target 0x200.
- Hit entry 0x40, update taken=0 -> hit_o=1, pred_taken_o=0, pred_target_o=0x44. With BTB_2BIT_PRED_EN: ctr 2'b10->2'b01, pred_taken_o=0; a second taken update returns it to 2'b10 (taken).
- Fill 4 entries, pulse flush_i -> busy_o=1 for exactly 16 cycles, hit_o=0 throughout, and all entries miss afterwards. A flush re-pulsed at cycle 5 extends busy to 5+16 cycles. An upd_valid_i during the sweep leaves no entry.
- Assert rst_n=0 asynchronously mid-sweep and mid-update -> outputs reset immediately (busy_o=0, hit_o=0). After release, all lookups miss.
